obstacle_scroller: RTL and testbench

- Multi-slot obstacle engine for the runner game. Replaces the single fixed cactus with NUM_OBS independent obstacle slots.
- Adds pseudo-random spawn spacing, a speed ramp, and a RUN/HIT state machine with a latched collision.
- Runs on the slow game-tick clock. Exports per-slot offsets and active flags so the pixel renderer (on the pixel clock) draws each sprite at left edge SPAWN_X - offset.

---
 rtl/obstacle_scroller.sv | 191 +++++++++++++++++++
 tb/tb_obstacle_scroller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scroller.sv
// Multi-slot obstacle engine on the game-tick clock: spawn spacing, speed ramp, RUN/HIT FSM.
// Optional retire score counter behind macro OBSTACLE_SCORE_EN.
module obstacle_scroller #(
   parameter int         NUM_OBS    = 3,
   parameter int         XW         = 10,
   parameter int         SPAWN_X    = 783,
   parameter int         EXIT_OX    = 670,
   parameter int         HIT_LO     = 473,
   parameter int         HIT_HI     = 660,
   parameter int         STEP_INIT  = 10,
   parameter int         STEP_MAX   = 20,
   parameter int         RAMP_TICKS = 500,
   parameter int         MIN_GAP    = 40,
   parameter logic [7:0] GAP_MASK   = 8'h3F
) (
   input  logic                  clk_obstacle,
   input  logic                  reset,
   input  logic                  game_run,
   input  logic                  dino_grounded,
   output logic [NUM_OBS*XW-1:0] obs_ox,
   output logic [NUM_OBS-1:0]    obs_active,
   output logic [5:0]            step,
   output logic                  collision,
   output logic [1:0]            state
`ifdef OBSTACLE_SCORE_EN
   ,
   output logic [15:0]           score
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HIT  = 2'b10
   } state_t;

   localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam int CW = $clog2(NUM_OBS + 1);

   // A sprite's left edge is SPAWN_X - ox, so never let a slot travel past SPAWN_X.
   localparam logic [XW:0]    EXIT_V     = (SPAWN_X < EXIT_OX) ? (XW+1)'(SPAWN_X) : (XW+1)'(EXIT_OX);
   localparam logic [XW-1:0]  HIT_LO_V   = XW'(HIT_LO);
   localparam logic [XW-1:0]  HIT_HI_V   = XW'(HIT_HI);
   localparam logic [5:0]     STEP_INI_V = 6'(STEP_INIT);
   localparam logic [5:0]     STEP_MAX_V = 6'(STEP_MAX);
   localparam logic [RW-1:0]  RAMP_LAST  = RW'(RAMP_TICKS - 1);
   localparam logic [RW-1:0]  RAMP_ONE   = RW'(1);
   localparam logic [7:0]     MIN_GAP_V  = 8'(MIN_GAP);
   localparam logic [NUM_OBS-1:0] SLOT_ONE = NUM_OBS'(1);

   state_t               state_q, state_d;
   logic [XW-1:0]        ox_q [NUM_OBS];
   logic [XW-1:0]        ox_d [NUM_OBS];
   logic [NUM_OBS-1:0]   act_q, act_d;
   logic [5:0]           step_q, step_d;
   logic [RW-1:0]        ramp_q, ramp_d;
   logic [7:0]           gap_q, gap_d;
   logic [7:0]           lfsr_q, lfsr_d;
   logic                 hit_now;
   logic                 moving;
   logic [NUM_OBS-1:0]   free_oh;
   logic [XW:0]          sum;
`ifdef OBSTACLE_SCORE_EN
   logic [15:0]          score_q, score_d;
   logic [CW-1:0]        retire_cnt;
   logic [16:0]          score_sum;
`endif

   always_comb begin
      hit_now = 1'b0;
      for (int i = 0; i < NUM_OBS; i++) begin
         if (act_q[i] && (ox_q[i] >= HIT_LO_V) && (ox_q[i] < HIT_HI_V))
            hit_now = 1'b1;
      end
      hit_now = hit_now & dino_grounded;
   end

   assign moving  = (state_q == S_RUN) && game_run && !hit_now;
   // One-hot of the lowest clear bit; zero when every slot is busy.
   assign free_oh = ~act_q & (act_q + SLOT_ONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (game_run) state_d = S_RUN;
         S_RUN:   if (game_run && hit_now) state_d = S_HIT;
         S_HIT:   state_d = S_HIT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ox_d   = ox_q;
      act_d  = act_q;
      step_d = step_q;
      ramp_d = ramp_q;
      gap_d  = gap_q;
      sum    = '0;
      lfsr_d = (lfsr_q == 8'h00) ? 8'hA5
             : {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`ifdef OBSTACLE_SCORE_EN
      retire_cnt = '0;
`endif
      if (state_q == S_IDLE)
         gap_d = MIN_GAP_V;
      if (moving) begin
         for (int i = 0; i < NUM_OBS; i++) begin
            if (act_q[i]) begin
               sum = {1'b0, ox_q[i]} + (XW+1)'(step_q);
               if (sum >= EXIT_V) begin
                  act_d[i] = 1'b0;
                  ox_d[i]  = '0;
`ifdef OBSTACLE_SCORE_EN
                  retire_cnt = retire_cnt + CW'(1);
`endif
               end else begin
                  ox_d[i] = sum[XW-1:0];
               end
            end
         end
         // Spawn judges free slots from pre-tick flags, so a slot retired now waits a tick.
         if (gap_q == 8'd0) begin
            if (|free_oh) begin
               for (int i = 0; i < NUM_OBS; i++) begin
                  if (free_oh[i]) begin
                     act_d[i] = 1'b1;
                     ox_d[i]  = '0;
                  end
               end
               gap_d = MIN_GAP_V + (lfsr_q & GAP_MASK);
            end
         end else begin
            gap_d = gap_q - 8'd1;
         end
         if (ramp_q == RAMP_LAST) begin
            ramp_d = '0;
            if (step_q < STEP_MAX_V)
               step_d = step_q + 6'd1;
         end else begin
            ramp_d = ramp_q + RAMP_ONE;
         end
      end
   end

`ifdef OBSTACLE_SCORE_EN
   always_comb begin
      score_sum = {1'b0, score_q} + 17'(retire_cnt);
      score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end
`endif

   always_ff @(posedge clk_obstacle) begin
      if (reset) begin
         state_q <= S_IDLE;
         for (int i = 0; i < NUM_OBS; i++) ox_q[i] <= '0;
         act_q   <= '0;
         step_q  <= STEP_INI_V;
         ramp_q  <= '0;
         gap_q   <= MIN_GAP_V;
         lfsr_q  <= 8'hA5;
`ifdef OBSTACLE_SCORE_EN
         score_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         for (int i = 0; i < NUM_OBS; i++) ox_q[i] <= ox_d[i];
         act_q   <= act_d;
         step_q  <= step_d;
         ramp_q  <= ramp_d;
         gap_q   <= gap_d;
         lfsr_q  <= lfsr_d;
`ifdef OBSTACLE_SCORE_EN
         score_q <= score_d;
`endif
      end
   end

   always_comb begin
      obs_ox = '0;
      for (int i = 0; i < NUM_OBS; i++) obs_ox[i*XW +: XW] = ox_q[i];
   end

   assign obs_active = act_q;
   assign step       = step_q;
   assign collision  = (state_q == S_HIT);
   assign state      = state_q;
`ifdef OBSTACLE_SCORE_EN
   assign score      = score_q;
`endif

endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller: a default instance and a short-gap instance that can fill
// every slot, both checked each tick against a behavioural model of the game rules.
module tb_obstacle_scroller;

   logic clk = 1'b0;
   logic rst, run, gnd;

   logic [29:0] dut_ox    [2];
   logic [2:0]  dut_act   [2];
   logic [5:0]  dut_step  [2];
   logic        dut_coll  [2];
   logic [1:0]  dut_state [2];
`ifdef OBSTACLE_SCORE_EN
   logic [15:0] dut_score [2];
`endif

   int checks   = 0;
   int failures = 0;
   int tick_n   = 0;

   // Behavioural model state, one set per instance (0 = default, 1 = fast spawn).
   int         m_ox   [2][3];
   bit         m_act  [2][3];
   int         m_step [2];
   int         m_ramp [2];
   int         m_gap  [2];
   int         m_st   [2];
   int         m_score[2];
   logic [7:0] m_lfsr [2];
   int         p_gap  [2] = '{40, 2};
   int         p_mask [2] = '{63, 3};

   always #5 clk = ~clk;

   obstacle_scroller u_dut (
      .clk_obstacle (clk),
      .reset        (rst),
      .game_run     (run),
      .dino_grounded(gnd),
      .obs_ox       (dut_ox[0]),
      .obs_active   (dut_act[0]),
      .step         (dut_step[0]),
      .collision    (dut_coll[0]),
      .state        (dut_state[0])
`ifdef OBSTACLE_SCORE_EN
      ,
      .score        (dut_score[0])
`endif
   );

   obstacle_scroller #(.MIN_GAP(2), .GAP_MASK(8'h03)) u_fast (
      .clk_obstacle (clk),
      .reset        (rst),
      .game_run     (run),
      .dino_grounded(gnd),
      .obs_ox       (dut_ox[1]),
      .obs_active   (dut_act[1]),
      .step         (dut_step[1]),
      .collision    (dut_coll[1]),
      .state        (dut_state[1])
`ifdef OBSTACLE_SCORE_EN
      ,
      .score        (dut_score[1])
`endif
   );

   task automatic model_tick(input int k);
      logic [7:0] old;
      bit         pre [3];
      bit         hit;
      int         sum;
      int         retired;
      int         free_i;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin m_ox[k][i] = 0; m_act[k][i] = 0; end
         m_step[k] = 10; m_ramp[k] = 0; m_gap[k] = p_gap[k]; m_st[k] = 0;
         m_score[k] = 0; m_lfsr[k] = 8'hA5;
         return;
      end
      old = m_lfsr[k];
      m_lfsr[k] = {old[6:0], ^(old & 8'hB8)};
      if (m_st[k] == 0) begin
         if (run) m_st[k] = 1;
      end else if (m_st[k] == 1 && run) begin
         hit = 0;
         for (int i = 0; i < 3; i++)
            if (m_act[k][i] && m_ox[k][i] >= 473 && m_ox[k][i] < 660 && gnd) hit = 1;
         if (hit) begin
            m_st[k] = 2;
         end else begin
            retired = 0;
            for (int i = 0; i < 3; i++) begin
               pre[i] = m_act[k][i];
               if (m_act[k][i]) begin
                  sum = m_ox[k][i] + m_step[k];
                  if (sum >= 670) begin
                     m_act[k][i] = 0; m_ox[k][i] = 0; retired++;
                  end else m_ox[k][i] = sum;
               end
            end
            if (m_gap[k] == 0) begin
               free_i = -1;
               for (int i = 2; i >= 0; i--) if (!pre[i]) free_i = i;
               if (free_i >= 0) begin
                  m_act[k][free_i] = 1; m_ox[k][free_i] = 0;
                  m_gap[k] = p_gap[k] + (int'(old) & p_mask[k]);
               end
            end else m_gap[k] = m_gap[k] - 1;
            if (m_ramp[k] == 499) begin
               m_ramp[k] = 0;
               if (m_step[k] < 20) m_step[k] = m_step[k] + 1;
            end else m_ramp[k] = m_ramp[k] + 1;
            m_score[k] = (m_score[k] + retired > 65535) ? 65535 : m_score[k] + retired;
         end
      end
   endtask

   task automatic compare_all(input int k);
      logic [29:0] e_ox;
      logic [2:0]  e_act;
      for (int i = 0; i < 3; i++) begin
         e_ox[i*10 +: 10] = 10'(m_ox[k][i]);
         e_act[i]         = m_act[k][i];
      end
      checks++;
      if (dut_state[k] !== 2'(m_st[k])) begin
         failures++;
         $display("FAIL model_state inst=%0d t=%0d got=%0d exp=%0d", k, tick_n, dut_state[k], m_st[k]);
      end
      checks++;
      if (dut_coll[k] !== (m_st[k] == 2)) begin
         failures++;
         $display("FAIL model_collision inst=%0d t=%0d got=%0b exp=%0b", k, tick_n, dut_coll[k], m_st[k] == 2);
      end
      checks++;
      if (dut_step[k] !== 6'(m_step[k])) begin
         failures++;
         $display("FAIL model_step inst=%0d t=%0d got=%0d exp=%0d", k, tick_n, dut_step[k], m_step[k]);
      end
      checks++;
      if (dut_act[k] !== e_act) begin
         failures++;
         $display("FAIL model_active inst=%0d t=%0d got=%b exp=%b", k, tick_n, dut_act[k], e_act);
      end
      checks++;
      if (dut_ox[k] !== e_ox) begin
         failures++;
         $display("FAIL model_ox inst=%0d t=%0d got=%h exp=%h", k, tick_n, dut_ox[k], e_ox);
      end
`ifdef OBSTACLE_SCORE_EN
      checks++;
      if (dut_score[k] !== 16'(m_score[k])) begin
         failures++;
         $display("FAIL model_score inst=%0d t=%0d got=%0d exp=%0d", k, tick_n, dut_score[k], m_score[k]);
      end
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      tick_n++;
      for (int k = 0; k < 2; k++) begin
         model_tick(k);
         compare_all(k);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0; gnd = 1'b0;
      tick(); tick();
      checks++;
      if (dut_state[0] !== 2'b00 || dut_coll[0] !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got=%0d/%0b exp=0/0", dut_state[0], dut_coll[0]);
      end
      checks++;
      if (dut_act[0] !== 3'b000 || dut_ox[0] !== 30'd0 || dut_step[0] !== 6'd10) begin
         failures++;
         $display("FAIL reset_slots act=%b ox=%h step=%0d exp act=000 ox=0 step=10",
                  dut_act[0], dut_ox[0], dut_step[0]);
      end
      rst = 1'b0;
      tick(); tick();
      checks++;
      if (dut_state[0] !== 2'b00) begin
         failures++;
         $display("FAIL idle_hold got=%0d exp=0", dut_state[0]);
      end
   endtask

   task automatic test_spawn_move();
      run = 1'b1; gnd = 1'b0; tick_n = 0;
      for (int n = 1; n <= 120; n++) begin
         tick();
         if (n == 1) begin
            checks++;
            if (dut_state[0] !== 2'b01) begin
               failures++;
               $display("FAIL enter_run got=%0d exp=1", dut_state[0]);
            end
         end
         if (n == 41) begin
            checks++;
            if (dut_act[0] !== 3'b000) begin
               failures++;
               $display("FAIL no_early_spawn got=%b exp=000", dut_act[0]);
            end
         end
         if (n == 42 || n == 43 || n == 44 || n == 108) begin
            checks++;
            if (dut_act[0][0] !== 1'b1 || dut_ox[0][9:0] !== 10'((n - 42) * 10)) begin
               failures++;
               $display("FAIL slot0_move n=%0d act=%b ox=%0d exp ox=%0d", n, dut_act[0][0],
                        dut_ox[0][9:0], (n - 42) * 10);
            end
         end
         if (n == 109) begin
            checks++;
            if (dut_act[0][0] !== 1'b0 || dut_ox[0][9:0] !== 10'd0) begin
               failures++;
               $display("FAIL slot0_retire act=%b ox=%0d exp act=0 ox=0", dut_act[0][0], dut_ox[0][9:0]);
            end
         end
      end
   endtask

   task automatic test_ramp();
      while (tick_n < 5600) begin
         tick();
         if (tick_n == 500 || tick_n == 501 || tick_n == 5600) begin
            checks++;
            if (dut_step[0] !== ((tick_n == 500) ? 6'd10 : (tick_n == 501) ? 6'd11 : 6'd20)) begin
               failures++;
               $display("FAIL ramp_step t=%0d got=%0d", tick_n, dut_step[0]);
            end
         end
      end
   endtask

   task automatic test_freeze();
      int snap_ox [3];
      int snap_step;
      for (int i = 0; i < 3; i++) snap_ox[i] = m_ox[0][i];
      snap_step = m_step[0];
      run = 1'b0;
      repeat (20) tick();
      checks++;
      if (dut_ox[0] !== {10'(snap_ox[2]), 10'(snap_ox[1]), 10'(snap_ox[0])} ||
          dut_step[0] !== 6'(snap_step) || dut_state[0] !== 2'b01) begin
         failures++;
         $display("FAIL freeze ox=%h step=%0d state=%0d", dut_ox[0], dut_step[0], dut_state[0]);
      end
      run = 1'b1;
   endtask

   task automatic test_hit();
      int limit = 0;
      logic [29:0] hit_ox;
      gnd = 1'b1;
      while (dut_state[0] !== 2'b10 && limit < 300) begin
         tick();
         limit++;
      end
      checks++;
      if (dut_state[0] !== 2'b10 || dut_coll[0] !== 1'b1) begin
         failures++;
         $display("FAIL hit_enter state=%0d coll=%0b exp=2/1", dut_state[0], dut_coll[0]);
      end
      for (int i = 0; i < 3; i++) hit_ox[i*10 +: 10] = 10'(m_ox[0][i]);
      for (int n = 0; n < 100; n++) begin
         run = 1'($urandom_range(0, 1));
         tick();
      end
      checks++;
      if (dut_ox[0] !== hit_ox || dut_state[0] !== 2'b10) begin
         failures++;
         $display("FAIL hit_freeze ox=%h exp=%h state=%0d", dut_ox[0], hit_ox, dut_state[0]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; run = 1'b0; gnd = 1'b0;
      checks++;
      if (dut_state[0] !== 2'b00 || dut_act[0] !== 3'b000 || dut_step[0] !== 6'd10 || dut_coll[0] !== 1'b0) begin
         failures++;
         $display("FAIL hit_reset state=%0d act=%b step=%0d exp 0/000/10", dut_state[0], dut_act[0], dut_step[0]);
      end
   endtask

   task automatic test_random();
      int full_seen = 0;
      for (int n = 0; n < 4000; n++) begin
         run = ($urandom_range(0, 19) != 0);
         gnd = ($urandom_range(0, 199) == 0);
         rst = ((m_st[0] == 2 || m_st[1] == 2) && $urandom_range(0, 7) == 0) ||
               ($urandom_range(0, 799) == 0);
         tick();
         if (m_act[1][0] && m_act[1][1] && m_act[1][2]) full_seen++;
      end
      rst = 1'b0;
      checks++;
      if (full_seen == 0) begin
         failures++;
         $display("FAIL random_all_slots_busy got=0 exp>0");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0d", tick_n);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_spawn_move();
      test_ramp();
      test_freeze();
      test_hit();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
